// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master shift engine: frames a DATA_WIDTH-bit exchange with cs_n,
// shifts mosi on detected SCK falls and captures miso on SCK rising pulses.
module spi_byte_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int CS_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  sck,
    input  logic                  sck_rising,
    input  logic                  miso,
    output logic                  sck_en,
    output logic                  spi_sck,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  sck_q, sck_falling;
    logic                  sck_en_q, sck_en_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  rx_valid_q, rx_valid_d;

    assign sck_falling = sck_q & ~sck;

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sck_en_d   = sck_en_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    cs_n_d     = 1'b0;
                    mosi_d     = (MSB_FIRST != 0) ? tx_data[DATA_WIDTH-1] : tx_data[0];
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    sck_en_d  = 1'b1;
                    state_d   = S_XFER;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_XFER: begin
                if (sck_rising) begin
                    rx_shift_d = (MSB_FIRST != 0) ? {rx_shift_q[DATA_WIDTH-2:0], miso}
                                                  : {miso, rx_shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_falling) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        sck_en_d = 1'b0;
                        state_d  = S_HOLD;
                    end else begin
                        // Rotate rather than shift: only the head bit ever reaches mosi.
                        tx_shift_d = (MSB_FIRST != 0)
                                   ? {tx_shift_q[DATA_WIDTH-2:0], tx_shift_q[DATA_WIDTH-1]}
                                   : {tx_shift_q[0], tx_shift_q[DATA_WIDTH-1:1]};
                        mosi_d     = (MSB_FIRST != 0) ? tx_shift_q[DATA_WIDTH-2] : tx_shift_q[1];
                    end
                end
            end
            S_HOLD: begin
                if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                cs_n_d     = 1'b1;
                mosi_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sck_q      <= 1'b0;
            sck_en_q   <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sck_q      <= sck;
            sck_en_q   <= sck_en_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign spi_sck  = sck;
    assign sck_en   = sck_en_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_byte_shifter.sv
// Bench for spi_byte_shifter: unit 0 is 8-bit MSB-first, unit 1 is 16-bit LSB-first,
// each fed by a simple SCK generator; one monitor checks both against a bit-level model.
module tb_spi_byte_shifter;
    localparam int CS_GAP = 4;
    localparam int N_LIT  = 7;
    localparam int HALF [2] = '{2, 3};
    localparam int LIT_U [N_LIT] = '{0, 0, 0, 0, 0, 1, 1};
    localparam logic [15:0] LIT_RX  [N_LIT] = '{16'h00A5, 16'h00FF, 16'h0000, 16'h00A5,
                                               16'h003C, 16'h0001, 16'h1234};
    localparam logic [15:0] LIT_SEQ [N_LIT] = '{16'h00A5, 16'h0000, 16'h00FF, 16'h00A5,
                                               16'h003C, 16'h8000, 16'h2C48};

    logic        clk, rst;
    logic        start_v [2];
    logic [15:0] tx_v [2];
    logic        sck_v [2], rise_v [2], miso_v [2], loop_v [2], mc_v [2];
    logic        sck_en_v [2], spi_sck_v [2], mosi_v [2], cs_n_v [2], busy_v [2], rxv_v [2];
    logic [7:0]  rx_a;
    logic [15:0] rx_b;
    logic [15:0] rx_v [2];
    int          gcnt [2];

    int checks = 0;
    int errors = 0;

    assign rx_v[0]   = {8'h00, rx_a};
    assign rx_v[1]   = rx_b;
    assign miso_v[0] = loop_v[0] ? mosi_v[0] : mc_v[0];
    assign miso_v[1] = loop_v[1] ? mosi_v[1] : mc_v[1];

    spi_byte_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1), .CS_GAP(CS_GAP)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .tx_data(tx_v[0][7:0]),
        .sck(sck_v[0]), .sck_rising(rise_v[0]), .miso(miso_v[0]),
        .sck_en(sck_en_v[0]), .spi_sck(spi_sck_v[0]), .mosi(mosi_v[0]), .cs_n(cs_n_v[0]),
        .busy(busy_v[0]), .rx_data(rx_a), .rx_valid(rxv_v[0]));

    spi_byte_shifter #(.DATA_WIDTH(16), .MSB_FIRST(0), .CS_GAP(CS_GAP)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .tx_data(tx_v[1]),
        .sck(sck_v[1]), .sck_rising(rise_v[1]), .miso(miso_v[1]),
        .sck_en(sck_en_v[1]), .spi_sck(spi_sck_v[1]), .mosi(mosi_v[1]), .cs_n(cs_n_v[1]),
        .busy(busy_v[1]), .rx_data(rx_b), .rx_valid(rxv_v[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SCK generator: toggles every HALF clk cycles while enabled, idles low otherwise.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst || !sck_en_v[u]) begin
                sck_v[u]  <= 1'b0;
                rise_v[u] <= 1'b0;
                gcnt[u]   <= 0;
            end else if (gcnt[u] == HALF[u] - 1) begin
                gcnt[u]   <= 0;
                sck_v[u]  <= ~sck_v[u];
                rise_v[u] <= ~sck_v[u];
            end else begin
                gcnt[u]   <= gcnt[u] + 1;
                rise_v[u] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor state: expected words and framing counters per unit.
    int          cyc [2], k [2], srise [2], pre_lo [2], post [2];
    bit          live [2], pend [2];
    logic [15:0] etx [2], erx [2], mseq [2], hold [2];
    logic        prev_cs [2], prev_sck [2], prev_busy [2], prev_rxv [2], prev_en [2];
    bit          rst_prev;
    int          lit_ptr;

    initial begin
        int w, idx;
        rst_prev = 1'b0;
        lit_ptr  = 0;
        for (int u = 0; u < 2; u++) begin
            cyc[u] = 0; k[u] = 0; srise[u] = 0; pre_lo[u] = 0; post[u] = 0;
            live[u] = 1'b0; pend[u] = 1'b0;
            etx[u] = '0; erx[u] = '0; mseq[u] = '0; hold[u] = '0;
            prev_cs[u] = 1'b1; prev_sck[u] = 1'b0; prev_busy[u] = 1'b0;
            prev_rxv[u] = 1'b0; prev_en[u] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                w = (u == 0) ? 8 : 16;
                if (rst_prev) begin
                    chk("rst_cs_n", cs_n_v[u], 1);
                    chk("rst_sck_en", sck_en_v[u], 0);
                    chk("rst_busy", busy_v[u], 0);
                    chk("rst_mosi", mosi_v[u], 0);
                    chk("rst_rx_data", rx_v[u], 0);
                    chk("rst_rx_valid", rxv_v[u], 0);
                end else if (!rst) begin
                    if (busy_v[u] && !prev_busy[u]) chk("busy_rise_needs_start", pend[u], 1);
                    if (pend[u]) begin
                        chk("accept_cs_n", cs_n_v[u], 0);
                        chk("accept_busy", busy_v[u], 1);
                        chk("first_mosi", mosi_v[u], etx[u][(u == 0) ? w - 1 : 0]);
                        pend[u] = 1'b0;
                    end
                    if (live[u]) begin
                        cyc[u]++;
                        if (sck_en_v[u] && !prev_en[u]) chk("sck_en_latency", cyc[u], CS_GAP + 1);
                        if (cyc[u] > 600) begin
                            chk("timeout_no_rx_valid", 1, 0);
                            live[u] = 1'b0;
                        end
                    end
                    if (!busy_v[u]) begin
                        chk("idle_cs_n", cs_n_v[u], 1);
                        chk("idle_sck_en", sck_en_v[u], 0);
                        chk("idle_mosi", mosi_v[u], 0);
                    end
                    if (cs_n_v[u] != prev_cs[u]) chk("sck_low_at_cs_edge", spi_sck_v[u], 0);
                    if (!cs_n_v[u]) begin
                        if (spi_sck_v[u] && !prev_sck[u]) begin
                            srise[u]++;
                            if (srise[u] == 1) chk("cs_lead_gap", pre_lo[u] >= CS_GAP, 1);
                        end
                        if (!spi_sck_v[u] && prev_sck[u]) post[u] = 1;
                        else if (srise[u] > 0) post[u]++;
                        if (srise[u] == 0) pre_lo[u]++;
                    end
                    if (cs_n_v[u] && !prev_cs[u]) begin
                        chk("sck_rise_count", srise[u], w);
                        chk("cs_trail_gap", post[u] >= CS_GAP, 1);
                        srise[u] = 0; pre_lo[u] = 0; post[u] = 0;
                    end
                    if (rise_v[u] && live[u]) begin
                        if (k[u] < w) begin
                            idx = (u == 0) ? w - 1 - k[u] : k[u];
                            chk("mosi_bit", mosi_v[u], etx[u][idx]);
                            erx[u][idx] = miso_v[u];
                            mseq[u] = {mseq[u][14:0], mosi_v[u]};
                        end
                        k[u]++;
                    end
                    if (rxv_v[u]) begin
                        chk("rx_valid_one_cycle", prev_rxv[u], 0);
                        chk("rx_valid_expected", live[u], 1);
                        chk("rx_data_model", rx_v[u], erx[u]);
                        chk("busy_low_with_rx_valid", busy_v[u], 0);
                        if (lit_ptr < N_LIT) begin
                            chk("lit_unit", u, LIT_U[lit_ptr]);
                            chk("lit_rx_data", rx_v[u], LIT_RX[lit_ptr]);
                            chk("lit_mosi_seq", mseq[u], LIT_SEQ[lit_ptr]);
                        end else begin
                            chk("extra_rx_valid", 1, 0);
                        end
                        lit_ptr++;
                        hold[u] = erx[u];
                        live[u] = 1'b0;
                    end else begin
                        chk("rx_data_hold", rx_v[u], hold[u]);
                    end
                end
                if (rst) begin
                    live[u] = 1'b0; pend[u] = 1'b0; hold[u] = '0;
                    srise[u] = 0; pre_lo[u] = 0; post[u] = 0;
                end else if (start_v[u] && !busy_v[u]) begin
                    pend[u] = 1'b1; live[u] = 1'b1; cyc[u] = 0; k[u] = 0;
                    etx[u] = (u == 0) ? {8'h00, tx_v[u][7:0]} : tx_v[u];
                    erx[u] = '0; mseq[u] = '0;
                end
                prev_cs[u]   = cs_n_v[u];
                prev_sck[u]  = spi_sck_v[u];
                prev_busy[u] = busy_v[u];
                prev_rxv[u]  = rxv_v[u];
                prev_en[u]   = sck_en_v[u];
            end
            rst_prev = rst;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int u);
        for (int i = 0; i < 600 && busy_v[u]; i++) step(1);
    endtask

    task automatic wait_rxv(input int u);
        for (int i = 0; i < 600 && !rxv_v[u]; i++) step(1);
    endtask

    task automatic run(input int u, input logic [15:0] d);
        start_v[u] = 1'b1;
        tx_v[u]    = d;
        step(1);
        start_v[u] = 1'b0;
        wait_idle(u);
        step(3);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0; tx_v[u] = '0; loop_v[u] = 1'b0; mc_v[u] = 1'b0;
        end
        start_v[0] = 1'b1;
        tx_v[0]    = 16'h00A5;
        step(3);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        step(3);

        loop_v[0] = 1'b1;
        run(0, 16'h00A5);
        loop_v[0] = 1'b0;
        mc_v[0]   = 1'b1;
        run(0, 16'h0000);
        mc_v[0] = 1'b0;
        run(0, 16'h00FF);

        // start mid-transfer must be dropped; start right after rx_valid must be taken
        loop_v[0]  = 1'b1;
        start_v[0] = 1'b1;
        tx_v[0]    = 16'h00A5;
        step(1);
        start_v[0] = 1'b0;
        step(20);
        start_v[0] = 1'b1;
        tx_v[0]    = 16'h003C;
        step(1);
        start_v[0] = 1'b0;
        wait_rxv(0);
        start_v[0] = 1'b1;
        tx_v[0]    = 16'h003C;
        step(1);
        start_v[0] = 1'b0;
        tx_v[0]    = 16'h00FF;
        wait_idle(0);
        step(3);

        // abort after the third rising edge
        start_v[0] = 1'b1;
        tx_v[0]    = 16'h00A5;
        step(1);
        start_v[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            if (rise_v[0]) n++;
            step(1);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(30);

        loop_v[1] = 1'b1;
        run(1, 16'h0001);
        run(1, 16'h1234);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_byte_shifter.md
# spi_byte_shifter

SPI mode-0 master shift engine that consumes the serial clock generator's `sck` and `rising_edge` outputs and drives its `en` input. It sends one `DATA_WIDTH`-bit word on `mosi` and captures one word from `miso` per transaction. It also frames each transaction with `cs_n`. The block sits between the bus-side controller, which issues `start`/`tx_data` and collects `rx_data`, and the SPI pins.

## Interface
- `DATA_WIDTH`, default 8: bits per transaction (≥2).
- `MSB_FIRST`, default 1: 1 = MSB shifted/captured first; 0 = LSB first.
- `CS_GAP`, default 4: clk cycles of `cs_n` low before the first SCK edge and after the last SCK edge (≥1).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transaction; accepted only in IDLE.
- `tx_data`  in  DATA_WIDTH  word to send; latched on accepted `start`.
- `sck`  in  1  serial clock from the generator.
- `sck_rising`  in  1  one-cycle pulse, coincident with `sck` going high.
- `miso`  in  1  serial data from the slave.
- `sck_en`  out  1  enable to the clock generator.
- `spi_sck`  out  1  SCK pin; equals `sck` (combinational pass-through).
- `mosi`  out  1  serial data to the slave.
- `cs_n`  out  1  chip select, active low.
- `busy`  out  1  high in every state except IDLE.
- `rx_data`  out  DATA_WIDTH  last captured word; holds its value until the next DONE.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.

## Operation
- Internal falling-edge detection:
  - `sck_q` is a registered copy of `sck`.
  - `sck_falling = sck_q & ~sck`.
- Bit counter `bit_cnt` is `$clog2(DATA_WIDTH+1)` bits wide and counts rising edges from 0 to `DATA_WIDTH`. It never wraps.
- IDLE:
  - Outputs: `cs_n`=1, `sck_en`=0, `mosi`=0, `busy`=0.
  - On `start`: load `tx_shift`←`tx_data`, clear `bit_cnt` and the gap counter, drive `cs_n`←0, drive `mosi`← first bit (`tx_data[DATA_WIDTH-1]` if `MSB_FIRST`, else `tx_data[0]`), go to SETUP.
- SETUP:
  - Count `CS_GAP` cycles.
  - On the last one: `sck_en`←1, go to XFER.
- XFER, on `sck_rising`:
  - Shift `miso` into `rx_shift`. With `MSB_FIRST` it enters at the LSB and shifts left; otherwise it enters at the MSB and shifts right.
  - `bit_cnt`++.
- XFER, on `sck_falling`:
  - If `bit_cnt`==`DATA_WIDTH`: `sck_en`←0, go to HOLD.
  - Otherwise, shift `tx_shift` and drive `mosi` with the next bit.
- HOLD:
  - `cs_n` stays low and `sck_en`=0.
  - Count `CS_GAP` cycles, then go to DONE.
- DONE (one cycle): `rx_data`←`rx_shift`, `rx_valid`←1, `cs_n`←1, `mosi`←0, then go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- `tx_data` is sampled only in the accepting cycle; later changes have no effect.
- `sck_rising` or `sck_falling` outside XFER is ignored.

## Timing
- All outputs are registered except `spi_sck`.
- Reset values: `sck_en`=0, `mosi`=0, `cs_n`=1, `busy`=0, `rx_data`=0, `rx_valid`=0. All internal state returns to IDLE.
- `rst` has priority over every other event. Asserting it mid-transaction deasserts `cs_n` and `sck_en` at the next clk edge. No `rx_valid` is produced for the aborted word.
- `start` accepted at edge t:
  - `cs_n`=0, `busy`=1 and the first `mosi` bit are visible after edge t.
  - `sck_en`=1 is visible after edge t+`CS_GAP`.
- MOSI timing:
  - Each subsequent `mosi` bit changes one clk after the falling edge is detected, so it is always stable across the next rising edge.
  - `mosi` is set up for the first rising edge from SETUP onward.
- With generator half-period H clk cycles, transaction length from `start` to `rx_valid` is approximately 2·`CS_GAP` + (2·`DATA_WIDTH`)·H + 3 cycles.
- Exactly `DATA_WIDTH` rising edges occur on `spi_sck` while `cs_n` is low. `spi_sck` is 0 whenever `cs_n` toggles.
- `rx_valid` and the falling edge of `busy` occur in the same cycle. A new `start` is accepted in the following cycle at the earliest.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → `cs_n`=1, `sck_en`=0, `mosi`=0, `busy`=0, `rx_data`=0, no `rx_valid`.
- Loopback, default parameters: `miso` tied to `mosi`, `tx_data`=0xA5 → 8 `spi_sck` rising edges inside the `cs_n`-low window, `mosi` bit sequence 1,0,1,0,0,1,0,1, `rx_data`=0xA5, `rx_valid` high exactly 1 cycle.
- `miso`=1 constant, `tx_data`=0x00 → `mosi` 0 for all bits, `rx_data`=0xFF. Then `miso`=0, `tx_data`=0xFF → `rx_data`=0x00.
- `start` pulsed again mid-XFER with `tx_data`=0x3C → ignored, first word completes unchanged. A `start` in the cycle after `rx_valid` with `tx_data`=0x3C → second transaction sends 0x3C.
- `rst` asserted after the 3rd rising edge of a 0xA5 transfer → next cycle `cs_n`=1, `sck_en`=0, `busy`=0. No `rx_valid` pulse, `rx_data` is 0.
- `MSB_FIRST`=0, `DATA_WIDTH`=16, loopback, `tx_data`=0x0001 → first `mosi` bit 1 then fifteen 0s, `rx_data`=0x0001. `cs_n` low lasts at least `CS_GAP` cycles before the first and after the last `spi_sck` edge.
